// File: rtl/oddeven_sort_pkg.sv
// Shared types and the key-compare rule for the odd-even transposition sorter.
package oddeven_sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  localparam int KEY_MAX_W = 64;

  // Flipping the key MSB maps two's complement onto offset binary, so one
  // unsigned compare serves both modes.
  function automatic logic key_swap(input logic [KEY_MAX_W-1:0] a,
                                    input logic [KEY_MAX_W-1:0] b,
                                    input logic                 sgn,
                                    input logic                 desc,
                                    input logic [5:0]           msb);
    logic [KEY_MAX_W-1:0] flip;
    logic [KEY_MAX_W-1:0] ab;
    logic [KEY_MAX_W-1:0] bb;
    flip      = '0;
    flip[msb] = sgn;
    ab        = a ^ flip;
    bb        = b ^ flip;
    return desc ? (ab < bb) : (ab > bb);
  endfunction

endpackage

// File: rtl/oddeven_sort_if.sv
// Host-side bus of the sorter: entry load, control, status and array readback.
interface oddeven_sort_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 7,
  parameter int CNT_W  = $clog2(DEPTH + 1)
);
  logic [DEPTH-1:0]        load_i;
  logic [DEPTH*DATA_W-1:0] writedata_i;
  logic [DEPTH*DATA_W-1:0] readdata_o;
  logic                    start_i;
  logic                    abort_i;
  logic                    descend_i;
  logic                    signed_i;
  logic                    busy_o;
  logic                    done_o;
  logic                    interrupt_o;
  logic [CNT_W-1:0]        phases_o;

  modport slave (
    input  load_i, writedata_i, start_i, abort_i, descend_i, signed_i,
    output readdata_o, busy_o, done_o, interrupt_o, phases_o
  );

  modport master (
    output load_i, writedata_i, start_i, abort_i, descend_i, signed_i,
    input  readdata_o, busy_o, done_o, interrupt_o, phases_o
  );
endinterface

// File: rtl/oddeven_sort_cmp_swap_cell.sv
// Combinational compare/exchange of one adjacent pair; lo_o/hi_o are the
// entries destined for the lower/higher index.
module cmp_swap_cell
  import oddeven_sort_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              sgn_i,
  input  logic              desc_i,
  output logic [DATA_W-1:0] lo_o,
  output logic [DATA_W-1:0] hi_o,
  output logic              swp_o
);

  assign swp_o = key_swap(KEY_MAX_W'(a_i), KEY_MAX_W'(b_i), sgn_i, desc_i,
                          6'(DATA_W - 1));
  assign lo_o  = swp_o ? b_i : a_i;
  assign hi_o  = swp_o ? a_i : b_i;

endmodule

// File: rtl/oddeven_sort.sv
// Odd-even transposition sorter: one compare phase per clock over DEPTH keys,
// with mode capture at start, early exit after two swap-free phases, and abort.
module oddeven_sort
  import oddeven_sort_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  oddeven_sort_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [DEPTH-1:0][DATA_W-1:0] arr_t;

  state_e           state_q, state_d;
  arr_t             ent_q, ent_d;
  arr_t             ph;
  logic             sgn_q, sgn_d;
  logic             desc_q, desc_d;
  logic             par_q, par_d;
  logic             zrun_q, zrun_d;
  logic             irq_q, irq_d;
  logic [CNT_W-1:0] phases_q, phases_d;
  logic             any_swp;
  logic             last_phase;

  generate
    if (DEPTH > 1) begin : g_net
      logic [DEPTH-2:0][DATA_W-1:0] lo;
      logic [DEPTH-2:0][DATA_W-1:0] hi;
      logic [DEPTH-2:0]             swp;
      logic [DEPTH-2:0]             act;

      for (genvar i = 0; i < DEPTH - 1; i++) begin : g_cell
        cmp_swap_cell #(.DATA_W(DATA_W)) u_cell (
          .a_i    (ent_q[i]),
          .b_i    (ent_q[i+1]),
          .sgn_i  (sgn_q),
          .desc_i (desc_q),
          .lo_o   (lo[i]),
          .hi_o   (hi[i]),
          .swp_o  (swp[i])
        );
        if (i % 2 == 0) begin : g_even
          assign act[i] = (par_q == EVEN);
        end else begin : g_odd
          assign act[i] = (par_q == ODD);
        end
      end

      // Active pairs never overlap within a phase, so sequential overwrite is safe.
      always_comb begin
        ph = ent_q;
        for (int i = 0; i < DEPTH - 1; i++) begin
          if (act[i]) begin
            ph[i]   = lo[i];
            ph[i+1] = hi[i];
          end
        end
      end

      assign any_swp = |(swp & act);
    end else begin : g_single
      assign ph      = ent_q;
      assign any_swp = 1'b0;
    end
  endgenerate

  assign last_phase = (phases_q == CNT_W'(DEPTH - 1));

  always_comb begin
    state_d  = state_q;
    ent_d    = ent_q;
    sgn_d    = sgn_q;
    desc_d   = desc_q;
    par_d    = par_q;
    zrun_d   = zrun_q;
    phases_d = phases_q;
    irq_d    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        for (int k = 0; k < DEPTH; k++) begin
          if (bus.load_i[k]) ent_d[k] = bus.writedata_i[k*DATA_W +: DATA_W];
        end
        if (state_q == DONE && (bus.abort_i || (|bus.load_i))) state_d = IDLE;
        if (bus.start_i && !(state_q == DONE && bus.abort_i)) begin
          // A single entry is trivially sorted, so skip straight to completion.
          state_d  = (DEPTH == 1) ? DONE : SORT;
          irq_d    = (DEPTH == 1);
          phases_d = '0;
          par_d    = EVEN;
          zrun_d   = 1'b0;
          sgn_d    = bus.signed_i;
          desc_d   = bus.descend_i;
        end
      end
      SORT: begin
        if (bus.abort_i) begin
          state_d = IDLE;
        end else begin
          ent_d    = ph;
          phases_d = phases_q + 1'b1;
          par_d    = ~par_q;
          zrun_d   = ~any_swp;
          if (last_phase || (zrun_q && !any_swp)) begin
            state_d = DONE;
            irq_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ent_q    <= '0;
      sgn_q    <= 1'b0;
      desc_q   <= 1'b0;
      par_q    <= EVEN;
      zrun_q   <= 1'b0;
      irq_q    <= 1'b0;
      phases_q <= '0;
    end else begin
      state_q  <= state_d;
      ent_q    <= ent_d;
      sgn_q    <= sgn_d;
      desc_q   <= desc_d;
      par_q    <= par_d;
      zrun_q   <= zrun_d;
      irq_q    <= irq_d;
      phases_q <= phases_d;
    end
  end

  assign bus.readdata_o  = ent_q;
  assign bus.busy_o      = (state_q == SORT);
  assign bus.done_o      = (state_q == DONE);
  assign bus.interrupt_o = irq_q;
  assign bus.phases_o    = phases_q;

endmodule

// File: doc/oddeven_sort.md
Name: oddeven_sort

Overview:
- Parametrised successor to the fixed 8-bit, 7-entry sort engine.
- Sorts DEPTH register-held keys of DATA_W bits using odd-even transposition: one compare phase per clock, all pairs of a phase compared in parallel.
- Adds run-time ascending/descending and signed/unsigned modes, early termination when the array is already sorted, and a phase counter.
- Sits behind the host load/start/done/interrupt interface, same as the earlier engine.

Parameters:
- DATA_W, 8, key width in bits (>=1).
- DEPTH, 7, number of entries (>=1).
- CNT_W, $clog2(DEPTH+1), width of the phase counter (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_i  in  DEPTH  per-entry write strobe.
- writedata_i  in  DEPTH*DATA_W  entry k at bits [k*DATA_W +: DATA_W].
- readdata_o  out  DEPTH*DATA_W  current array contents, same packing.
- start_i  in  1  start sort (level sampled).
- abort_i  in  1  abort a running sort.
- descend_i  in  1  0 = ascending (entry 0 smallest), 1 = descending.
- signed_i  in  1  1 = compare keys as two's complement.
- busy_o  out  1  high while sorting.
- done_o  out  1  level; array sorted and valid.
- interrupt_o  out  1  one-cycle completion pulse.
- phases_o  out  CNT_W  phases executed in the last or current run.

Behaviour:
- Reset (async, rst_n=0):
  - all entries = 0; state IDLE.
  - busy_o = 0, done_o = 0, interrupt_o = 0, phases_o = 0.
- States: IDLE, SORT, DONE.
- IDLE / DONE:
  - load_i[k]=1 writes writedata_i slice k at the clock edge.
  - Any load in DONE moves to IDLE and clears done_o.
  - start_i=1 moves to SORT next edge; phases_o <= 0; phase parity <= even; done_o <= 0.
  - If load and start are asserted together, the load is written and the sort runs on the loaded values.
- Mode sampling:
  - descend_i and signed_i are captured into mode registers on start acceptance.
  - Changes to either during SORT are ignored.
- SORT, one phase per cycle:
  - Even phase compares pairs (0,1),(2,3),...; odd phase compares (1,2),(3,4),...
  - An unpaired end entry holds.
  - Ascending: swap when e[i] > e[i+1]. Descending: swap when e[i] < e[i+1].
  - Equal keys never swap (stable).
  - Parity toggles every phase; phases_o increments every phase.
  - load_i and start_i are ignored in SORT.
- Termination:
  - After a phase with phases_o+1 == DEPTH, or after two consecutive phases with zero swaps, go to DONE on the next edge.
  - On DONE entry: done_o=1 and interrupt_o=1 for exactly that first DONE cycle.
  - Already-sorted input finishes in exactly 2 phases. The worst case is DEPTH phases.
- DEPTH=1: start moves straight to DONE after one cycle with phases_o=0; interrupt still pulses.
- Abort:
  - abort_i in SORT moves to IDLE next edge. Array keeps its partial contents; done_o=0; no interrupt.
  - Abort has priority over completion in the same cycle.
  - abort_i in DONE moves to IDLE and clears done_o.
  - abort_i in IDLE has no effect.
- busy_o = (state == SORT). readdata_o is a direct register view, so no output latency.
- Reset mid-sort: immediate return to reset values, with no interrupt.

Decomposition:
- Package oddeven_sort_pkg:
  - state enum {IDLE, SORT, DONE}.
  - phase-parity constants EVEN=0, ODD=1.
  - a key-compare function taking (a, b, signed, descend) and returning a swap flag.
- Sub-module cmp_swap_cell (parameter DATA_W):
  - combinational compare/exchange of one pair;
  - outputs the low and high entries plus a swapped flag;
  - instantiated DEPTH-1 times in a generate loop, with the active pairs selected by phase parity.

Test Plan:
- Load 80,40,10,20,30,70,50 (DEPTH=7, ascending, unsigned), start.
  - Required: readdata 10,20,30,40,50,70,80.
  - Required: interrupt_o pulses once, done_o stays 1, phases_o <= 7.
- Same data with descend_i=1.
  - Required: 80,70,50,40,30,20,10.
- Signed mode, data 0x7F,0x80,0x00,0xFF,0x01,0x02,0x03.
  - Required: 0x80,0xFF,0x00,0x01,0x02,0x03,0x7F.
  - Unsigned mode on the same data must give 0x00,0x01,0x02,0x03,0x7F,0x80,0xFF.
- Already sorted 1..7.
  - Required: DONE after exactly 2 phases, phases_o=2.
  - Reverse-sorted 7..1 must give phases_o=7 and result 1..7.
- Assert abort_i 3 cycles after start on 80,40,10,20,30,70,50.
  - Required: IDLE next cycle, busy_o=0, done_o=0, no interrupt, partial array held.
  - A subsequent start must complete correctly.
- Loads and starts during SORT are ignored.
- rst_n pulsed low mid-sort: all outputs 0 asynchronously.
- A load in DONE clears done_o.
